vinstr_eb_multi_slot: RTL



---
 rtl/vinstr_eb_multi_slot.sv | 95 +++++++++
 1 files changed

// File: rtl/vinstr_eb_multi_slot.sv
// Multi-slot elastic buffer between scalar issue and the vector decoder.
// In-order valid/ready queue with optional fall-through, flush and stats.
module vinstr_eb_multi_slot #(
  parameter int DATA_W      = 96,
  parameter int DEPTH       = 4,
  parameter int FALLTHROUGH = 0,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  max_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic FT = (FALLTHROUGH != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic              live, full, empty;
  logic              push, pop, wr_en, rd_en;

  assign live  = rst_n & ~flush_i;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign ready_out = live & ~full;
  assign valid_out = live & (~empty | (FT & valid_in));
  assign data_out  = (FT && empty) ? data_in : mem_q[rd_ptr_q];

  assign push = valid_in & ready_out;
  assign pop  = valid_out & ready_in;

  // An empty-buffer pop can only be a bypass word, which is never stored.
  assign wr_en = push & ~(empty & pop);
  assign rd_en = pop & ~empty;

  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign max_count_o = max_q;

  // Next pointers, occupancy and watermark.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CNT_W'(1);
    end
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  // Control state: reset beats flush, flush keeps the watermark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule
